// File: rtl/reg_file_if.sv
// reg_file_if -- ROB <-> architectural register file bundle.
//
// Carries every ROB-facing signal of reg_file except the clock, reset and
// global ready, which stay plain module ports.
//   master : ROB side. Drives source queries, the rd rename, the commit port
//            and the misprediction flush. Receives the operand answers.
//   slave  : register file side. Sees the same signals with the directions
//            swapped.
// ROB_W and XLEN must match the parameters of the reg_file it connects to.
interface reg_file_if #(
  parameter int ROB_W = 4,
  parameter int XLEN  = 32
);
  // Misprediction flush
  logic             rob_rst_enable;

  // Source operand queries and their answers
  logic [4:0]       rob2reg_rs1_request;
  logic [4:0]       rob2reg_rs2_request;
  logic [XLEN-1:0]  reg2rob_rs1_value;
  logic [XLEN-1:0]  reg2rob_rs2_value;
  logic [ROB_W-1:0] reg2rob_rs1_rename;
  logic [ROB_W-1:0] reg2rob_rs2_rename;
  logic             reg2rob_rs1_if_rename;
  logic             reg2rob_rs2_if_rename;

  // Destination rename at issue
  logic             rob2reg_rename_enable;
  logic [4:0]       rob2reg_rd_request;
  logic [ROB_W-1:0] rob2reg_rename_reorder;

  // Retirement
  logic             rob2reg_commit_enable;
  logic [4:0]       rob2reg_commit_des;
  logic [XLEN-1:0]  rob2reg_commit_value;
  logic [ROB_W-1:0] rob2reg_commit_reorder;

  modport master (
    output rob_rst_enable,
    output rob2reg_rs1_request, rob2reg_rs2_request,
    input  reg2rob_rs1_value, reg2rob_rs2_value,
    input  reg2rob_rs1_rename, reg2rob_rs2_rename,
    input  reg2rob_rs1_if_rename, reg2rob_rs2_if_rename,
    output rob2reg_rename_enable, rob2reg_rd_request, rob2reg_rename_reorder,
    output rob2reg_commit_enable, rob2reg_commit_des,
    output rob2reg_commit_value, rob2reg_commit_reorder
  );

  modport slave (
    input  rob_rst_enable,
    input  rob2reg_rs1_request, rob2reg_rs2_request,
    output reg2rob_rs1_value, reg2rob_rs2_value,
    output reg2rob_rs1_rename, reg2rob_rs2_rename,
    output reg2rob_rs1_if_rename, reg2rob_rs2_if_rename,
    input  rob2reg_rename_enable, rob2reg_rd_request, rob2reg_rename_reorder,
    input  rob2reg_commit_enable, rob2reg_commit_des,
    input  rob2reg_commit_value, rob2reg_commit_reorder
  );
endinterface

// File: rtl/reg_file.sv
// reg_file -- architectural register file with per-register rename tags.
//
// Holds 32 committed values plus a busy bit and producing ROB tag per
// register. Source queries are answered combinationally with either the
// committed value or the ROB tag that will produce it; a same-cycle commit
// is forwarded. Renames and commits update state at the clock edge.
//
// Ports:
//   clk_in  : clock
//   rst_in  : synchronous active-high reset, clears values, busy and tags
//   rdy_in  : global ready; no state changes while low, reads stay live
//   bus     : reg_file_if.slave -- queries, answers, rename, commit, flush
module reg_file #(
  parameter int ROB_W = 4,
  parameter int XLEN  = 32
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  reg_file_if.slave  bus
);

  logic [XLEN-1:0]  value_q [32];
  logic [XLEN-1:0]  value_d [32];
  logic [31:0]      busy_q;
  logic [31:0]      busy_d;
  logic [ROB_W-1:0] tag_q   [32];
  logic [ROB_W-1:0] tag_d   [32];

  // ---------------------------------------------------------------------
  // Next-state. The rename is applied after the commit so that, on the same
  // register, the new mapping wins over the busy clear of the old one. A
  // flush still lets the commit value land (the flushing JALR retires its
  // own rd) but drops any rename.
  // ---------------------------------------------------------------------
  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;

    if (bus.rob2reg_commit_enable && bus.rob2reg_commit_des != 5'd0) begin
      value_d[bus.rob2reg_commit_des] = bus.rob2reg_commit_value;
      // Only the producer currently mapped may release the register; an
      // older producer (stale tag) just leaves its value behind.
      if (busy_q[bus.rob2reg_commit_des] &&
          tag_q[bus.rob2reg_commit_des] == bus.rob2reg_commit_reorder) begin
        busy_d[bus.rob2reg_commit_des] = 1'b0;
      end
    end

    if (bus.rob_rst_enable) begin
      busy_d = '0;
    end else if (bus.rob2reg_rename_enable && bus.rob2reg_rd_request != 5'd0) begin
      busy_d[bus.rob2reg_rd_request] = 1'b1;
      tag_d[bus.rob2reg_rd_request]  = bus.rob2reg_rename_reorder;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

  // ---------------------------------------------------------------------
  // Read ports. Purely from current state and the commit inputs, so a
  // same-cycle rename of the issuing instruction's rd cannot disturb its
  // own source operands.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      logic [4:0]       req;
      logic             commit_hit;
      logic [XLEN-1:0]  rd_value;
      logic [ROB_W-1:0] rd_tag;
      logic             rd_pending;

      assign req = (gi == 0) ? bus.rob2reg_rs1_request : bus.rob2reg_rs2_request;
      assign commit_hit = bus.rob2reg_commit_enable && (bus.rob2reg_commit_des == req);

      always_comb begin
        rd_value   = '0;
        rd_tag     = '0;
        rd_pending = 1'b0;
        if (req != 5'd0) begin
          rd_value   = commit_hit ? bus.rob2reg_commit_value : value_q[req];
          // Still pending unless the retiring entry is the current producer.
          rd_pending = busy_q[req] &&
                       !(commit_hit && bus.rob2reg_commit_reorder == tag_q[req]);
          rd_tag     = rd_pending ? tag_q[req] : '0;
        end
      end
    end
  endgenerate

  assign bus.reg2rob_rs1_value     = g_read[0].rd_value;
  assign bus.reg2rob_rs1_rename    = g_read[0].rd_tag;
  assign bus.reg2rob_rs1_if_rename = g_read[0].rd_pending;
  assign bus.reg2rob_rs2_value     = g_read[1].rd_value;
  assign bus.reg2rob_rs2_rename    = g_read[1].rd_tag;
  assign bus.reg2rob_rs2_if_rename = g_read[1].rd_pending;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file -- scoreboard bench for reg_file.
//
// A stimulus process drives one input set per cycle, computes the expected
// read answers from a register-level reference model and queues them. A
// monitor process pops one expectation per cycle on the falling edge and
// compares it against the DUT outputs. Directed scenarios come first,
// followed by randomized traffic including flushes, rdy drops and resets.
module tb_reg_file;
  localparam int ROB_W = 4;
  localparam int XLEN  = 32;

  logic clk;
  logic rst;
  logic rdy;

  reg_file_if #(.ROB_W(ROB_W), .XLEN(XLEN)) bus ();

  reg_file #(.ROB_W(ROB_W), .XLEN(XLEN)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             rdy;
    logic             flush;
    logic             ren_en;
    logic [4:0]       rd;
    logic [ROB_W-1:0] ren_tag;
    logic             c_en;
    logic [4:0]       c_des;
    logic [XLEN-1:0]  c_val;
    logic [ROB_W-1:0] c_tag;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
  } stim_t;

  typedef struct {
    logic [4:0]       a1;
    logic [4:0]       a2;
    logic [XLEN-1:0]  v1;
    logic [XLEN-1:0]  v2;
    logic [ROB_W-1:0] r1;
    logic [ROB_W-1:0] r2;
    logic             f1;
    logic             f2;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  // Reference model: the architectural view of the register file.
  logic [XLEN-1:0]  m_val  [32];
  logic             m_busy [32];
  logic [ROB_W-1:0] m_tag  [32];

  stim_t cur;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.rdy = 1'b1; s.flush = 1'b0;
    s.ren_en = 1'b0; s.rd = '0; s.ren_tag = '0;
    s.c_en = 1'b0; s.c_des = '0; s.c_val = '0; s.c_tag = '0;
    s.rs1 = '0; s.rs2 = '0;
    return s;
  endfunction

  // Operand answer for one source, from the model and this cycle's commit.
  task automatic model_read(input stim_t s, input logic [4:0] a,
                            output logic [XLEN-1:0] v, output logic [ROB_W-1:0] r,
                            output logic f);
    logic retiring;
    v = '0; r = '0; f = 1'b0;
    if (a != 5'd0) begin
      retiring = s.c_en && (s.c_des == a);
      v = retiring ? s.c_val : m_val[a];
      f = m_busy[a] && !(retiring && s.c_tag == m_tag[a]);
      r = f ? m_tag[a] : '0;
    end
  endtask

  // Apply the effect of one clock edge with inputs s.
  task automatic model_edge(input stim_t s);
    logic             was_busy;
    logic [ROB_W-1:0] was_tag;
    if (s.rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (s.rdy) begin
      if (s.c_en && s.c_des != 5'd0) begin
        was_busy = m_busy[s.c_des];
        was_tag  = m_tag[s.c_des];
        m_val[s.c_des] = s.c_val;
        if (was_busy && was_tag == s.c_tag) m_busy[s.c_des] = 1'b0;
      end
      if (s.flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (s.ren_en && s.rd != 5'd0) begin
        m_busy[s.rd] = 1'b1;
        m_tag[s.rd]  = s.ren_tag;
      end
    end
  endtask

  task automatic drive(input stim_t s);
    rst = s.rst;
    rdy = s.rdy;
    bus.rob_rst_enable         = s.flush;
    bus.rob2reg_rename_enable  = s.ren_en;
    bus.rob2reg_rd_request     = s.rd;
    bus.rob2reg_rename_reorder = s.ren_tag;
    bus.rob2reg_commit_enable  = s.c_en;
    bus.rob2reg_commit_des     = s.c_des;
    bus.rob2reg_commit_value   = s.c_val;
    bus.rob2reg_commit_reorder = s.c_tag;
    bus.rob2reg_rs1_request    = s.rs1;
    bus.rob2reg_rs2_request    = s.rs2;
  endtask

  // One cycle: let the edge consume the previous inputs, then present s.
  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    model_edge(cur);
    #1;
    drive(s);
    cur = s;
    e.a1 = s.rs1;
    e.a2 = s.rs2;
    model_read(s, s.rs1, e.v1, e.r1, e.f1);
    model_read(s, s.rs2, e.v2, e.r2, e.f2);
    sb.push_back(e);
  endtask

  // Monitor: compare one queued expectation per cycle.
  always @(negedge clk) begin
    exp_t e;
    logic bad;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      bad = 1'b0;
      if (bus.reg2rob_rs1_value !== e.v1) begin
        bad = 1'b1;
        $display("FAIL rs1_value x%0d: got %h expected %h", e.a1, bus.reg2rob_rs1_value, e.v1);
      end
      if (bus.reg2rob_rs1_if_rename !== e.f1 || bus.reg2rob_rs1_rename !== e.r1) begin
        bad = 1'b1;
        $display("FAIL rs1_rename x%0d: got if=%0b tag=%0d expected if=%0b tag=%0d",
                 e.a1, bus.reg2rob_rs1_if_rename, bus.reg2rob_rs1_rename, e.f1, e.r1);
      end
      if (bus.reg2rob_rs2_value !== e.v2) begin
        bad = 1'b1;
        $display("FAIL rs2_value x%0d: got %h expected %h", e.a2, bus.reg2rob_rs2_value, e.v2);
      end
      if (bus.reg2rob_rs2_if_rename !== e.f2 || bus.reg2rob_rs2_rename !== e.r2) begin
        bad = 1'b1;
        $display("FAIL rs2_rename x%0d: got if=%0b tag=%0d expected if=%0b tag=%0d",
                 e.a2, bus.reg2rob_rs2_if_rename, bus.reg2rob_rs2_rename, e.f2, e.r2);
      end
      if (bad) miscompares++;
      $display("vec %0d: rs1=x%0d val=%h pend=%0b tag=%0d | rs2=x%0d val=%h pend=%0b tag=%0d",
               vectors, e.a1, bus.reg2rob_rs1_value, bus.reg2rob_rs1_if_rename,
               bus.reg2rob_rs1_rename, e.a2, bus.reg2rob_rs2_value,
               bus.reg2rob_rs2_if_rename, bus.reg2rob_rs2_rename);
    end
  end

  function automatic logic [4:0] pick_reg();
    logic [4:0] r;
    r = 5'($urandom_range(0, 9));
    if ($urandom_range(0, 15) == 0) r = 5'd31;
    return r;
  endfunction

  initial begin
    stim_t s;
    vectors = 0;
    miscompares = 0;
    // Model starts unknown-free; the first edge is a reset anyway.
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
    s = idle();
    s.rst = 1'b1;
    drive(s);
    cur = s;
    apply(s);

    // Reset: queries read 0 after release.
    s = idle(); s.rs1 = 5'd5; s.rs2 = 5'd0; apply(s);

    // Rename then commit with bypass.
    s = idle(); s.ren_en = 1'b1; s.rd = 5'd3; s.ren_tag = 4'd7; apply(s);
    s = idle(); s.rs1 = 5'd3; apply(s);
    s = idle(); s.rs1 = 5'd3; s.c_en = 1'b1; s.c_des = 5'd3;
    s.c_val = 32'hDEADBEEF; s.c_tag = 4'd7; apply(s);
    s = idle(); s.rs1 = 5'd3; apply(s);

    // Stale commit.
    s = idle(); s.ren_en = 1'b1; s.rd = 5'd4; s.ren_tag = 4'd2; apply(s);
    s = idle(); s.ren_en = 1'b1; s.rd = 5'd4; s.ren_tag = 4'd9; apply(s);
    s = idle(); s.rs1 = 5'd4; s.c_en = 1'b1; s.c_des = 5'd4;
    s.c_val = 32'h11; s.c_tag = 4'd2; apply(s);
    s = idle(); s.rs1 = 5'd4; apply(s);
    s = idle(); s.rs2 = 5'd4; s.c_en = 1'b1; s.c_des = 5'd4;
    s.c_val = 32'h22; s.c_tag = 4'd9; apply(s);
    s = idle(); s.rs2 = 5'd4; apply(s);

    // Simultaneous commit and rename on x6.
    s = idle(); s.ren_en = 1'b1; s.rd = 5'd6; s.ren_tag = 4'd1; apply(s);
    s = idle(); s.rs1 = 5'd6; s.c_en = 1'b1; s.c_des = 5'd6; s.c_val = 32'h55;
    s.c_tag = 4'd1; s.ren_en = 1'b1; s.rd = 5'd6; s.ren_tag = 4'd3; apply(s);
    s = idle(); s.rs1 = 5'd6; apply(s);

    // Flush with same-cycle commit and rename.
    s = idle(); s.ren_en = 1'b1; s.rd = 5'd1;  s.ren_tag = 4'd4; apply(s);
    s = idle(); s.ren_en = 1'b1; s.rd = 5'd2;  s.ren_tag = 4'd5; apply(s);
    s = idle(); s.ren_en = 1'b1; s.rd = 5'd31; s.ren_tag = 4'd6; apply(s);
    s = idle(); s.rs1 = 5'd1; s.rs2 = 5'd31; s.flush = 1'b1; s.c_en = 1'b1;
    s.c_des = 5'd1; s.c_val = 32'h99; s.c_tag = 4'd4;
    s.ren_en = 1'b1; s.rd = 5'd7; s.ren_tag = 4'd8; apply(s);
    s = idle(); s.rs1 = 5'd1; s.rs2 = 5'd2; apply(s);
    s = idle(); s.rs1 = 5'd31; s.rs2 = 5'd7; apply(s);

    // x0 and rdy_in.
    s = idle(); s.rs1 = 5'd0; s.ren_en = 1'b1; s.rd = 5'd0; s.ren_tag = 4'd5;
    s.c_en = 1'b1; s.c_des = 5'd0; s.c_val = 32'hFF; apply(s);
    s = idle(); s.rs1 = 5'd0; apply(s);
    s = idle(); s.rdy = 1'b0; s.ren_en = 1'b1; s.rd = 5'd8; s.ren_tag = 4'd2; apply(s);
    s = idle(); s.rs1 = 5'd8; apply(s);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      s = idle();
      s.rst    = ($urandom_range(0, 199) == 0);
      s.rdy    = ($urandom_range(0, 7) != 0);
      s.flush  = ($urandom_range(0, 19) == 0);
      s.ren_en = ($urandom_range(0, 1) == 1);
      s.rd     = pick_reg();
      s.ren_tag = ROB_W'($urandom);
      s.c_en   = ($urandom_range(0, 1) == 1);
      s.c_des  = pick_reg();
      s.c_val  = $urandom;
      s.c_tag  = ($urandom_range(0, 1) == 1) ? m_tag[s.c_des] : ROB_W'($urandom);
      s.rs1    = ($urandom_range(0, 1) == 1) ? s.c_des : pick_reg();
      s.rs2    = ($urandom_range(0, 2) == 0) ? s.rd : pick_reg();
      apply(s);
    end

    // Drain: the last expectation is consumed on the next falling edge.
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
